// File: rtl/rib_arbiter_pkg.sv
// Shared constants and types for the rib bus arbiter.
// Optional round-robin low tier is enabled with RIB_ARB_RR_EN.
package rib_arbiter_pkg;

  localparam logic [1:0] RIB_M_CORE = 2'd0;
  localparam logic [1:0] RIB_M_PC   = 2'd1;
  localparam logic [1:0] RIB_M_JTAG = 2'd2;
  localparam logic [1:0] RIB_M_UART = 2'd3;

  localparam int RIB_ARB_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    RIB_ARB_IDLE  = 2'd0,
    RIB_ARB_GRANT = 2'd1,
    RIB_ARB_ERR   = 2'd2
  } rib_arb_state_e;

  function automatic logic [3:0] idx_to_onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rib_arb_prio.sv
// Combinational winner selection: uart > jtag > low tier (core/pc).
// With RIB_ARB_RR_EN the low tier alternates using last_low.
module rib_arb_prio
  import rib_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic       last_low,
  output logic [3:0] win_oh,
  output logic [1:0] win_idx,
  output logic       win_vld
);

  always_comb begin
    win_idx = RIB_M_CORE;
    if (req[RIB_M_UART]) begin
      win_idx = RIB_M_UART;
    end else if (req[RIB_M_JTAG]) begin
      win_idx = RIB_M_JTAG;
    end else if (req[RIB_M_CORE] && req[RIB_M_PC]) begin
`ifdef RIB_ARB_RR_EN
      // last_low names the low-tier master served last, so pick the other one
      win_idx = last_low ? RIB_M_CORE : RIB_M_PC;
`else
      win_idx = RIB_M_CORE;
`endif
    end else if (req[RIB_M_PC]) begin
      win_idx = RIB_M_PC;
    end
  end

`ifndef RIB_ARB_RR_EN
  logic unused_last_low;
  assign unused_last_low = last_low;
`endif

  assign win_vld = |req;
  assign win_oh  = win_vld ? idx_to_onehot(win_idx) : 4'b0000;

endmodule

// File: rtl/rib_arbiter.sv
// Registered four-master rib bus arbiter with slave timeout.
// Define RIB_ARB_RR_EN for round-robin between core and pc masters.
module rib_arbiter
  import rib_arbiter_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = RIB_ARB_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       slv_ready_i,
  output logic [3:0] grant_o,
  output logic [1:0] grant_idx_o,
  output logic       grant_vld_o,
  output logic       done_o,
  output logic       hold_flag_o,
  output logic       timeout_o,
  output logic [1:0] err_idx_o
);

  rib_arb_state_e       state;
  logic [TIMEOUT_W-1:0] cnt;
  logic [3:0]           win_oh;
  logic [1:0]           win_idx;
  logic                 win_vld;
  logic                 complete;
  logic                 withdraw;
  logic                 eff_low;

  assign complete = (state == RIB_ARB_GRANT) && req_i[grant_idx_o] && slv_ready_i;
  assign withdraw = (state == RIB_ARB_GRANT) && !req_i[grant_idx_o];

`ifdef RIB_ARB_RR_EN
  logic last_low;
  // A low-tier completion this cycle must already steer the back-to-back pick
  assign eff_low = (complete && !grant_idx_o[1]) ? grant_idx_o[0] : last_low;
`else
  assign eff_low = 1'b1;
`endif

  rib_arb_prio u_prio (
    .req      (req_i),
    .last_low (eff_low),
    .win_oh   (win_oh),
    .win_idx  (win_idx),
    .win_vld  (win_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RIB_ARB_IDLE;
      grant_o     <= 4'b0000;
      grant_idx_o <= 2'd0;
      grant_vld_o <= 1'b0;
      done_o      <= 1'b0;
      hold_flag_o <= 1'b0;
      timeout_o   <= 1'b0;
      err_idx_o   <= 2'd0;
      cnt         <= '0;
`ifdef RIB_ARB_RR_EN
      last_low    <= 1'b1;
`endif
    end else begin
      done_o    <= 1'b0;
      timeout_o <= 1'b0;
      case (state)
        RIB_ARB_IDLE: begin
          hold_flag_o <= req_i[RIB_M_JTAG] | req_i[RIB_M_UART];
          if (win_vld) begin
            state       <= RIB_ARB_GRANT;
            grant_o     <= win_oh;
            grant_idx_o <= win_idx;
            grant_vld_o <= 1'b1;
            cnt         <= '0;
          end
        end
        RIB_ARB_GRANT: begin
          if (complete) begin
            done_o <= 1'b1;
`ifdef RIB_ARB_RR_EN
            last_low <= eff_low;
`endif
            cnt <= '0;
            if (win_vld) begin
              grant_o     <= win_oh;
              grant_idx_o <= win_idx;
              hold_flag_o <= win_idx[1];
            end else begin
              state       <= RIB_ARB_IDLE;
              grant_o     <= 4'b0000;
              grant_idx_o <= 2'd0;
              grant_vld_o <= 1'b0;
              hold_flag_o <= 1'b0;
            end
          end else if (withdraw) begin
            state       <= RIB_ARB_IDLE;
            grant_o     <= 4'b0000;
            grant_idx_o <= 2'd0;
            grant_vld_o <= 1'b0;
            hold_flag_o <= 1'b0;
            cnt         <= '0;
          end else if (cnt == TIMEOUT_W'(TIMEOUT - 1)) begin
            state       <= RIB_ARB_ERR;
            err_idx_o   <= grant_idx_o;
            timeout_o   <= 1'b1;
            grant_o     <= 4'b0000;
            grant_idx_o <= 2'd0;
            grant_vld_o <= 1'b0;
            hold_flag_o <= 1'b0;
            cnt         <= '0;
          end else if (cnt != {TIMEOUT_W{1'b1}}) begin
            cnt <= cnt + 1'b1;
          end
        end
        RIB_ARB_ERR: begin
          state       <= RIB_ARB_IDLE;
          hold_flag_o <= req_i[RIB_M_JTAG] | req_i[RIB_M_UART];
        end
        default: begin
          state       <= RIB_ARB_IDLE;
          grant_o     <= 4'b0000;
          grant_idx_o <= 2'd0;
          grant_vld_o <= 1'b0;
          hold_flag_o <= 1'b0;
          cnt         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// Directed-vector bench for rib_arbiter built with TIMEOUT=8.
// Expectations follow RIB_ARB_RR_EN when the macro is defined.
module tb_rib_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_i;
  logic       slv_ready_i;
  logic [3:0] grant_o;
  logic [1:0] grant_idx_o;
  logic       grant_vld_o;
  logic       done_o;
  logic       hold_flag_o;
  logic       timeout_o;
  logic [1:0] err_idx_o;

  int compared;
  int mismatched;

  rib_arbiter #(.TIMEOUT_W(8), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .slv_ready_i (slv_ready_i),
    .grant_o     (grant_o),
    .grant_idx_o (grant_idx_o),
    .grant_vld_o (grant_vld_o),
    .done_o      (done_o),
    .hold_flag_o (hold_flag_o),
    .timeout_o   (timeout_o),
    .err_idx_o   (err_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    req_i       = r;
    slv_ready_i = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] rr_exp [4];
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b0;
    req_i       = 4'b0000;
    slv_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant", {4'b0, grant_o}, 8'h0);
    checkOutput("rst_idx", {6'b0, grant_idx_o}, 8'h0);
    checkOutput("rst_vld", {7'b0, grant_vld_o}, 8'h0);
    checkOutput("rst_done", {7'b0, done_o}, 8'h0);
    checkOutput("rst_hold", {7'b0, hold_flag_o}, 8'h0);
    checkOutput("rst_timeout", {7'b0, timeout_o}, 8'h0);
    checkOutput("rst_err_idx", {6'b0, err_idx_o}, 8'h0);
    rst = 1'b1;

    // Priority from IDLE, one cycle latency
    applyStimulus(4'b1111, 1'b0);
    checkOutput("prio_all_grant", {4'b0, grant_o}, 8'h8);
    checkOutput("prio_all_idx", {6'b0, grant_idx_o}, 8'h3);
    checkOutput("prio_all_vld", {7'b0, grant_vld_o}, 8'h1);
    checkOutput("prio_all_hold", {7'b0, hold_flag_o}, 8'h1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("withdraw3_vld", {7'b0, grant_vld_o}, 8'h0);
    checkOutput("withdraw3_done", {7'b0, done_o}, 8'h0);
    applyStimulus(4'b0111, 1'b0);
    checkOutput("prio_jtag_grant", {4'b0, grant_o}, 8'h4);
    checkOutput("prio_jtag_hold", {7'b0, hold_flag_o}, 8'h1);
    applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0011, 1'b0);
    checkOutput("prio_core_idx", {6'b0, grant_idx_o}, 8'h0);
    checkOutput("prio_core_hold", {7'b0, hold_flag_o}, 8'h0);

    // Multi-cycle slave: higher request waits, then takes over back-to-back
    for (int i = 0; i < 5; i++) begin
      applyStimulus(4'b1001, 1'b0);
      checkOutput($sformatf("wait_idx_%0d", i), {6'b0, grant_idx_o}, 8'h0);
      checkOutput($sformatf("wait_vld_%0d", i), {7'b0, grant_vld_o}, 8'h1);
      checkOutput($sformatf("wait_done_%0d", i), {7'b0, done_o}, 8'h0);
    end
    applyStimulus(4'b1001, 1'b1);
    checkOutput("b2b_done", {7'b0, done_o}, 8'h1);
    checkOutput("b2b_grant", {4'b0, grant_o}, 8'h8);
    checkOutput("b2b_hold", {7'b0, hold_flag_o}, 8'h1);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("b2b_idle_vld", {7'b0, grant_vld_o}, 8'h0);
    checkOutput("b2b_idle_done", {7'b0, done_o}, 8'h0);

    // Timeout after 8 GRANT cycles, owner 2
    applyStimulus(4'b0100, 1'b0);
    checkOutput("to_grant_idx", {6'b0, grant_idx_o}, 8'h2);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(4'b0100, 1'b0);
      checkOutput($sformatf("to_wait_%0d", i), {7'b0, timeout_o}, 8'h0);
    end
    checkOutput("to_still_vld", {7'b0, grant_vld_o}, 8'h1);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("to_pulse", {7'b0, timeout_o}, 8'h1);
    checkOutput("to_vld", {7'b0, grant_vld_o}, 8'h0);
    checkOutput("to_grant", {4'b0, grant_o}, 8'h0);
    checkOutput("to_err_idx", {6'b0, err_idx_o}, 8'h2);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("err_exit_timeout", {7'b0, timeout_o}, 8'h0);
    checkOutput("err_exit_vld", {7'b0, grant_vld_o}, 8'h0);
    checkOutput("err_exit_hold", {7'b0, hold_flag_o}, 8'h1);
    checkOutput("err_idx_kept", {6'b0, err_idx_o}, 8'h2);
    applyStimulus(4'b1000, 1'b0);
    checkOutput("after_err_idx", {6'b0, grant_idx_o}, 8'h3);
    applyStimulus(4'b0000, 1'b0);

    // Ready arriving on the timeout cycle completes normally
    applyStimulus(4'b0001, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(4'b0001, 1'b0);
    applyStimulus(4'b0001, 1'b1);
    checkOutput("race_done", {7'b0, done_o}, 8'h1);
    checkOutput("race_timeout", {7'b0, timeout_o}, 8'h0);
    checkOutput("race_vld", {7'b0, grant_vld_o}, 8'h1);
    checkOutput("race_err_idx", {6'b0, err_idx_o}, 8'h2);
    applyStimulus(4'b0000, 1'b0);

    // Withdraw of pc before ready
    applyStimulus(4'b0010, 1'b0);
    checkOutput("pc_idx", {6'b0, grant_idx_o}, 8'h1);
    checkOutput("pc_grant", {4'b0, grant_o}, 8'h2);
    applyStimulus(4'b0000, 1'b0);
    checkOutput("pc_withdraw_vld", {7'b0, grant_vld_o}, 8'h0);
    checkOutput("pc_withdraw_done", {7'b0, done_o}, 8'h0);

    // Asynchronous reset in the middle of a grant
    applyStimulus(4'b1000, 1'b0);
    checkOutput("pre_rst_vld", {7'b0, grant_vld_o}, 8'h1);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_grant", {4'b0, grant_o}, 8'h0);
    checkOutput("async_rst_vld", {7'b0, grant_vld_o}, 8'h0);
    checkOutput("async_rst_hold", {7'b0, hold_flag_o}, 8'h0);
    req_i = 4'b0000;
    @(posedge clk);
    #1;
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b0);
    checkOutput("post_rst_done", {7'b0, done_o}, 8'h0);
    checkOutput("post_rst_timeout", {7'b0, timeout_o}, 8'h0);

    // Low tier sharing between core and pc
`ifdef RIB_ARB_RR_EN
    rr_exp = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    rr_exp = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0011, 1'b1);
      checkOutput($sformatf("low_idx_%0d", i), {6'b0, grant_idx_o}, {6'b0, rr_exp[i]});
      checkOutput($sformatf("low_done_%0d", i), {7'b0, done_o}, (i == 0) ? 8'h0 : 8'h1);
    end
    applyStimulus(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rib_arbiter.md
Name: rib_arbiter

Overview:
- Registered bus arbiter that shares the rib slave fabric between four masters: core load/store, PC fetch, JTAG, and UART download.
- Issues a one-hot grant and holds it until the addressed slave completes the access. Slaves complete in one cycle (rom/ram/gpio) or after several cycles (i2c ready).
- Generates the core hold flag and a slave-timeout error.
- The rib datapath muxes consume grant_idx_o; this block carries no address or data.

Parameters:
- TIMEOUT_W, 8: width of the wait-cycle counter.
- TIMEOUT, 255: number of GRANT cycles without slave ready before abort; must be ≤ 2^TIMEOUT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- req_i  in  4  request per master: [0] core ex, [1] pc, [2] jtag, [3] uart_debug
- slv_ready_i  in  1  ready of the slave currently selected by the fabric
- grant_o  out  4  one-hot grant, registered
- grant_idx_o  out  2  encoded owner, registered
- grant_vld_o  out  1  a grant is active
- done_o  out  1  1-cycle pulse: owner's access completed
- hold_flag_o  out  1  stall request to the core, registered
- timeout_o  out  1  1-cycle pulse: access aborted by timeout
- err_idx_o  out  2  owner at the last timeout; holds its value until the next timeout

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant_o=0, grant_idx_o=0, grant_vld_o=0, done_o=0, hold_flag_o=0, timeout_o=0, err_idx_o=0, wait counter=0.
- States: IDLE, GRANT, ERR.
- Fixed priority, highest first: 3 (uart_debug) > 2 (jtag) > 0 (core ex) > 1 (pc).
- IDLE:
  - If any req_i is set, latch the winner, go to GRANT, and assert grant_o/grant_vld_o on the next edge. Arbitration latency is 1 cycle.
  - If no req_i is set, stay in IDLE.
- GRANT, with owner o:
  - If req_i[o]=1 and slv_ready_i=1: done_o pulses next cycle.
    - If any req_i is set this cycle, re-arbitrate immediately (back-to-back; the same master may win again) and stay in GRANT with the new owner and counter=0.
    - Otherwise go to IDLE.
  - If req_i[o]=0 (master withdrew): go to IDLE; no done_o pulse.
  - Otherwise the counter increments. When counter==TIMEOUT-1 and ready is still absent: go to ERR, latch err_idx_o=o, clear the grant.
- ERR, one cycle: timeout_o=1, grant_vld_o=0, then IDLE. Requests present during ERR are arbitrated in the following IDLE cycle.
- Owner-change invariant: the owner never changes while grant_vld_o=1 unless the owner completes, withdraws, or times out. A higher-priority request never preempts an active grant.
- Simultaneous ready and timeout: ready wins; the access completes normally.
- hold_flag_o: registered; equals 1 when the next owner is 2 or 3, or when req_i[2]|req_i[3] is set while in IDLE/ERR. Otherwise 0.
- The counter saturates and is cleared on every grant change.
- rst asserted mid-access drops the grant asynchronously; no done_o or timeout_o pulse is produced.

Optional Feature:
- Macro: RIB_ARB_RR_EN.
- Defined: masters 0 and 1 share the lowest priority tier round-robin. After a completed grant to one of them, the other is preferred when both request. Masters 3 and 2 stay above them with fixed priority. One extra state bit (last_low), reset to 1 so that master 0 is favoured first.
- Undefined: strict fixed priority as above; master 1 can be starved by master 0.

Decomposition:
- defines.vh gains:
  - master index constants RIB_M_CORE=0, RIB_M_PC=1, RIB_M_JTAG=2, RIB_M_UART=3;
  - state encodings RIB_ARB_IDLE/GRANT/ERR (2 bits);
  - the default timeout value.
- One combinational sub-module, rib_arb_prio: takes req[3:0] and last_low and returns a one-hot winner plus its index. It is reused for both IDLE arbitration and back-to-back re-arbitration.

Test Plan:
- Simultaneous requests: req_i=4'b1111 with slv_ready_i=1 → grant_idx_o sequence 3,2,0,0,… as each master drops its req after its done_o. First grant appears 1 cycle after req.
- Multi-cycle slave: owner=0, slv_ready_i held low for 5 cycles while req_i[3] rises → grant stays on 0 for all 5 cycles. done_o pulses, then grant moves to 3 in the same cycle; hold_flag_o=1.
- Timeout: TIMEOUT=8, owner=2, slv_ready_i=0 → after 8 GRANT cycles timeout_o pulses for 1 cycle and err_idx_o=2; IDLE next.
- Ready and timeout on the same cycle → done_o=1, timeout_o=0.
- Withdraw: owner=1 drops req_i[1] before ready → IDLE next cycle, no done_o. Async rst low mid-GRANT → all outputs 0 immediately.
- RIB_ARB_RR_EN defined, req_i[1:0]=2'b11, ready=1 → grants alternate 0,1,0,1. Undefined → all grants go to 0.
